sync_fifo_rd_stream: RTL and testbench

//  Read-side master for a single-clock pointer FIFO: 1-cycle registered read latency, rd_en/data_out/empty port.

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_rd_stream.sv | 97 +++++++++
 tb/tb_sync_fifo_rd_stream.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock pointer FIFO and its read-side stream master.
// Occupancy encoding and output buffer depth.
package sync_fifo_pkg;

    typedef logic [1:0] occ_t;

    localparam int OUT_BUF_DEPTH = 2;

endpackage

// File: rtl/sync_fifo_rd_stream.sv
// Read-side master for a 1-cycle-latency FIFO read port.
// Issues rd_en only when a buffer slot is guaranteed, streams words out as valid/ready.
module sync_fifo_rd_stream
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output occ_t                  occupancy
);

    logic [DATA_WIDTH-1:0] entry [OUT_BUF_DEPTH];
    logic                  wr_idx;
    logic                  rd_idx;
    occ_t                  count;
    logic                  rd_pending;
    logic                  pop;
    logic                  push;
    occ_t                  fill;

    assign pop  = m_valid && m_ready;
    assign push = rd_pending && !flush;
    assign fill = count + occ_t'(rd_pending);

    // A read is only issued if its word is sure to find a free slot on arrival.
    assign fifo_rd_en = !flush && !fifo_empty && ((fill - occ_t'(pop)) < 2'd2);

    assign m_valid   = (count != 2'd0);
    assign m_data    = entry[rd_idx];
    assign occupancy = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= fifo_rd_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < OUT_BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else if (push) begin
            entry[wr_idx] <= fifo_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_idx <= 1'b0;
            rd_idx <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_idx <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && (count == 2'd2) && !pop)
    );

    a_rd_not_empty : assert property (
        @(posedge clk) disable iff (!rst_n)
        fifo_rd_en |-> !fifo_empty
    );

    a_hold_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !flush) |=> $stable(m_data)
    );

endmodule

// File: tb/tb_sync_fifo_rd_stream.sv
// Bench for sync_fifo_rd_stream: behavioural FIFO, queue-based reference of owned words,
// directed latency/backpressure/flush cases and a randomized ready/write run.
module tb_sync_fifo_rd_stream;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [1:0] occupancy;

    logic       wr_en;
    logic [7:0] wr_data;

    int n_cmp;
    int n_bad;
    int n_out;
    int fcnt;
    bit mon_en;

    logic [7:0] fq[$];
    logic [7:0] held[$];
    logic [7:0] pend[$];

    sync_fifo_rd_stream #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .occupancy  (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Depth-16 FIFO with registered read data.
    assign fifo_empty = (fcnt == 0);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fcnt      <= 0;
            fifo_data <= 8'h00;
        end else begin
            if (fifo_rd_en && fq.size() != 0) begin
                fifo_data <= fq.pop_front();
            end
            if (wr_en && fq.size() < 16) begin
                fq.push_back(wr_data);
            end
            fcnt <= fq.size();
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: held = words that have arrived, pend = word requested last cycle.
    bit mpop;
    int mh;
    int mown;
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            mh = held.size();
            chk("m_valid", {31'd0, m_valid}, {31'd0, mh != 0});
            chk("occupancy", {30'd0, occupancy}, mh);
            if (mh != 0) begin
                chk("m_data", {24'd0, m_data}, {24'd0, held[0]});
            end
            mpop = m_valid && m_ready;
            mown = mh + pend.size() - ((mpop && mh != 0) ? 1 : 0);
            chk("fifo_rd_en", {31'd0, fifo_rd_en},
                {31'd0, !flush && fq.size() != 0 && mown < 2});
            if (mpop && mh != 0) begin
                void'(held.pop_front());
                n_out++;
            end
            if (flush) begin
                held.delete();
                pend.delete();
            end else begin
                if (pend.size() != 0) begin
                    held.push_back(pend.pop_front());
                end
                if (fifo_rd_en && fq.size() != 0) begin
                    pend.push_back(fq[0]);
                end
            end
        end
    end

    task automatic prefill(input int n, input int base);
        flush = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            wr_en   = 1'b1;
            wr_data = 8'(base + i);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic count_run(input string tag, input int exp);
        int  run;
        bit  started;
        bit  done;
        run     = 0;
        started = 0;
        done    = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (m_valid) begin
                started = 1;
                run++;
            end else if (started) begin
                done = 1;
            end
        end
        chk(tag, run, exp);
    endtask

    task automatic flush_case(input string tag, input bit rdy);
        logic [7:0] exp;
        bit         seen;
        prefill(10, 8'h40);
        flush   = 1'b0;
        m_ready = rdy;
        repeat (4) tick();
        flush = 1'b1;
        @(negedge clk);
        chk({tag, "_occ_pre"}, {30'd0, occupancy}, rdy ? 1 : 2);
        chk({tag, "_fifo_nonempty"}, {31'd0, fq.size() != 0}, 1);
        exp = (fq.size() != 0) ? fq[0] : 8'hxx;
        tick();
        flush   = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_occ_post"}, {30'd0, occupancy}, 0);
        chk({tag, "_valid_post"}, {31'd0, m_valid}, 0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (m_valid) begin
                seen = 1;
                chk({tag, "_next_word"}, {24'd0, m_data}, {24'd0, exp});
            end
        end
        if (!seen) begin
            chk({tag, "_valid_timeout"}, 0, 1);
        end
        repeat (12) tick();
    endtask

    initial begin
        int sent;
        int start_out;
        n_cmp   = 0;
        n_bad   = 0;
        n_out   = 0;
        mon_en  = 0;
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, m_valid}, 0);
        chk("rst_occ", {30'd0, occupancy}, 0);
        tick();
        rst_n  = 1'b1;
        mon_en = 1;

        // Idle after reset with the FIFO empty.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_rd_en", {31'd0, fifo_rd_en}, 0);
            chk("idle_data", {24'd0, m_data}, 0);
        end

        // Single word latency.
        tick();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        m_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("lat_rd_en_c1", {31'd0, fifo_rd_en}, 1);
        tick();
        @(negedge clk);
        chk("lat_valid_c2", {31'd0, m_valid}, 0);
        tick();
        @(negedge clk);
        chk("lat_valid_c3", {31'd0, m_valid}, 1);
        chk("lat_data_c3", {24'd0, m_data}, 8'hA5);
        tick();
        @(negedge clk);
        chk("lat_occ_c4", {30'd0, occupancy}, 0);

        // Full FIFO drained at one word per cycle.
        prefill(16, 0);
        flush   = 1'b0;
        m_ready = 1'b1;
        count_run("burst16_run", 16);
        chk("burst16_fifo_empty", fcnt, 0);

        // Backpressure then release.
        prefill(5, 8'h80);
        flush   = 1'b0;
        m_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("bp_occ", {30'd0, occupancy}, 2);
        chk("bp_rd_en", {31'd0, fifo_rd_en}, 0);
        chk("bp_fifo_left", fcnt, 3);
        tick();
        m_ready = 1'b1;
        count_run("bp_run", 5);

        flush_case("flush_full", 1'b0);
        flush_case("flush_stream", 1'b1);

        // Random traffic and ready.
        sent      = 0;
        start_out = n_out;
        for (int c = 0; c < 20000 && (n_out - start_out) < 1000; c++) begin
            tick();
            wr_en   = (sent < 1000) && (fcnt < 16) && ($urandom_range(0, 3) != 0);
            wr_data = 8'($urandom);
            if (wr_en) begin
                sent++;
            end
            m_ready = 1'($urandom_range(0, 1));
        end
        tick();
        wr_en = 1'b0;
        chk("rand_words_out", n_out - start_out, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
